// File: rtl/wb_stage.sv
// ============================================================================
// Module      : wb_stage
// Description : Write-back stage. Retires ALU results, waits on data-memory
//               responses for loads, then extracts and extends the load data
//               for the register-file write port.
//               Optional: WB_INSTRET_EN adds a 64-bit retired-instruction count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage #(
   parameter int DATA_WIDTH  = 32,
   parameter int RADDR_WIDTH = 5
) (
   input  logic                   clk_in,
   input  logic                   reset_in,
   input  logic                   mem_valid_in,
   input  logic                   mem_we_in,
   input  logic [RADDR_WIDTH-1:0] mem_waddr_in,
   input  logic [DATA_WIDTH-1:0]  mem_result_in,
   input  logic                   mem_is_load_in,
   input  logic [2:0]             mem_funct3_in,
   input  logic [1:0]             mem_addr_lo_in,
   input  logic                   flush_in,
   input  logic                   dmem_rvalid_in,
   input  logic [DATA_WIDTH-1:0]  dmem_rdata_in,
   output logic                   we_out,
   output logic [RADDR_WIDTH-1:0] waddr_out,
   output logic [DATA_WIDTH-1:0]  wdata_out,
   output logic                   stall_req_out,
   output logic                   misalign_out
`ifdef WB_INSTRET_EN
   ,
   output logic [63:0]            instret_out
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WB   = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [1:0]             r_state;
   logic [1:0]             w_next_state;
   logic                   w_stall;
   logic                   w_accept;
   logic                   w_resp;
   logic                   w_cap_misalign;
   logic [7:0]             w_byte;
   logic [15:0]            w_half;
   logic [DATA_WIDTH-1:0]  w_load_data;

   logic                   r_we;
   logic                   r_we_out;
   logic [RADDR_WIDTH-1:0] r_waddr;
   logic [DATA_WIDTH-1:0]  r_wdata;
   logic [2:0]             r_funct3;
   logic [1:0]             r_off;
   logic                   r_mis;
   logic                   r_misalign_out;

   // State register
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: S_IDLE and S_WB both capture a new instruction
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_WAIT: begin
            if (dmem_rvalid_in) begin
               w_next_state = S_WB;
            end
         end
         default: begin
            if (w_accept) begin
               w_next_state = mem_is_load_in ? S_WAIT : S_WB;
            end else begin
               w_next_state = S_IDLE;
            end
         end
      endcase
   end

   // Output / control decode from state
   always_comb begin
      w_stall  = (r_state == S_WAIT);
      w_accept = ~w_stall & mem_valid_in & ~flush_in;
      w_resp   = w_stall & dmem_rvalid_in;
   end

   // funct3[1:0]: 00 byte, 01 half, anything else treated as a word access
   always_comb begin
      w_cap_misalign = 1'b0;
      case (mem_funct3_in[1:0])
         2'b00:   w_cap_misalign = 1'b0;
         2'b01:   w_cap_misalign = mem_addr_lo_in[0];
         default: w_cap_misalign = (mem_addr_lo_in != 2'b00);
      endcase
   end

   always_comb begin
      w_byte      = dmem_rdata_in[{r_off, 3'b000} +: 8];
      w_half      = dmem_rdata_in[{r_off[1], 4'b0000} +: 16];
      w_load_data = dmem_rdata_in;
      case (r_funct3)
         3'b000:  w_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
         3'b100:  w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
         3'b001:  w_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
         3'b101:  w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
         default: w_load_data = dmem_rdata_in;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         r_we           <= 1'b0;
         r_we_out       <= 1'b0;
         r_waddr        <= '0;
         r_wdata        <= '0;
         r_funct3       <= 3'b000;
         r_off          <= 2'b00;
         r_mis          <= 1'b0;
         r_misalign_out <= 1'b0;
      end else begin
         r_misalign_out <= 1'b0;
         if (w_resp) begin
            r_wdata        <= w_load_data;
            r_we_out       <= r_we & (r_waddr != '0) & ~r_mis;
            r_misalign_out <= r_mis;
         end else if (!w_stall) begin
            if (w_accept) begin
               r_waddr <= mem_waddr_in;
               r_we    <= mem_we_in;
               if (mem_is_load_in) begin
                  r_funct3 <= mem_funct3_in;
                  r_off    <= mem_addr_lo_in;
                  r_mis    <= w_cap_misalign;
                  r_we_out <= 1'b0;
               end else begin
                  r_wdata  <= mem_result_in;
                  r_mis    <= 1'b0;
                  r_we_out <= mem_we_in & (mem_waddr_in != '0);
               end
            end else begin
               r_we_out <= 1'b0;
            end
         end
      end
   end

`ifdef WB_INSTRET_EN
   logic [63:0] r_instret;

   // A faulted (misaligned) load still passes through S_WB but does not retire
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         r_instret <= 64'd0;
      end else if ((r_state == S_WB) && !r_mis) begin
         r_instret <= r_instret + 64'd1;
      end
   end

   assign instret_out = r_instret;
`endif

   assign we_out        = r_we_out;
   assign waddr_out     = r_waddr;
   assign wdata_out     = r_wdata;
   assign stall_req_out = w_stall;
   assign misalign_out  = r_misalign_out;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// Module      : tb_wb_stage
// Description : Scoreboard bench for wb_stage: directed scenarios followed by
//               randomized ALU/load traffic against a behavioural load model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stage;

   logic        clk_in = 1'b0;
   logic        reset_in;
   logic        mem_valid_in, mem_we_in, mem_is_load_in, flush_in, dmem_rvalid_in;
   logic [4:0]  mem_waddr_in;
   logic [31:0] mem_result_in, dmem_rdata_in;
   logic [2:0]  mem_funct3_in;
   logic [1:0]  mem_addr_lo_in;
   logic        we_out, stall_req_out, misalign_out;
   logic [4:0]  waddr_out;
   logic [31:0] wdata_out;
`ifdef WB_INSTRET_EN
   logic [63:0] instret_out;
`endif

   wb_stage #(.DATA_WIDTH(32), .RADDR_WIDTH(5)) dut (
      .clk_in         (clk_in),
      .reset_in       (reset_in),
      .mem_valid_in   (mem_valid_in),
      .mem_we_in      (mem_we_in),
      .mem_waddr_in   (mem_waddr_in),
      .mem_result_in  (mem_result_in),
      .mem_is_load_in (mem_is_load_in),
      .mem_funct3_in  (mem_funct3_in),
      .mem_addr_lo_in (mem_addr_lo_in),
      .flush_in       (flush_in),
      .dmem_rvalid_in (dmem_rvalid_in),
      .dmem_rdata_in  (dmem_rdata_in),
      .we_out         (we_out),
      .waddr_out      (waddr_out),
      .wdata_out      (wdata_out),
      .stall_req_out  (stall_req_out),
      .misalign_out   (misalign_out)
`ifdef WB_INSTRET_EN
      ,
      .instret_out    (instret_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int          cyc;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        mis;
   } wb_event_t;

   wb_event_t   sb[$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   longint      instret_exp = 0;

   always @(posedge clk_in) cyc++;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference load behaviour: returns {misaligned, extended data}
   function automatic logic [32:0] ref_load(logic [2:0] f3, logic [1:0] off, logic [31:0] rdata);
      logic [31:0]        sh;
      logic signed [7:0]  sb8;
      logic signed [15:0] sh16;
      int                 v;
      sh = rdata >> (8 * off);
      case (f3)
         3'b000: begin sb8 = sh[7:0];  v = sb8;  return {1'b0, 32'(v)}; end
         3'b100: return {1'b0, 32'(sh[7:0])};
         3'b001: begin
            if (off % 2 != 0) return {1'b1, 32'd0};
            sh16 = sh[15:0]; v = sh16; return {1'b0, 32'(v)};
         end
         3'b101: begin
            if (off % 2 != 0) return {1'b1, 32'd0};
            return {1'b0, 32'(sh[15:0])};
         end
         default: begin
            if (off != 0) return {1'b1, 32'd0};
            return {1'b0, rdata};
         end
      endcase
   endfunction

   // Monitor: every write or misalign pulse must match the next expected event
   always @(negedge clk_in) begin
      if (reset_in === 1'b1 && (we_out === 1'b1 || misalign_out === 1'b1)) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got we=%0b waddr=%0d wdata=0x%0h mis=%0b expected no event (cycle %0d)",
                     we_out, waddr_out, wdata_out, misalign_out, cyc);
         end else begin
            wb_event_t e;
            e = sb.pop_front();
            chk("event_cycle", 64'(cyc), 64'(e.cyc));
            chk("event_we", 64'(we_out), 64'(e.we));
            chk("event_misalign", 64'(misalign_out), 64'(e.mis));
            if (e.we) begin
               chk("event_waddr", 64'(waddr_out), 64'(e.waddr));
               chk("event_wdata", 64'(wdata_out), 64'(e.wdata));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic quiet();
      mem_valid_in   = 1'b0;
      flush_in       = 1'b0;
      dmem_rvalid_in = 1'b0;
      mem_we_in      = 1'($urandom);
      mem_waddr_in   = 5'($urandom);
      mem_result_in  = $urandom;
      mem_is_load_in = 1'($urandom);
      mem_funct3_in  = 3'($urandom);
      mem_addr_lo_in = 2'($urandom);
      dmem_rdata_in  = $urandom;
   endtask

   task automatic issue_alu(input logic we, input logic [4:0] rd, input logic [31:0] res, input logic fl);
      chk("alu_no_stall", 64'(stall_req_out), 64'd0);
      mem_valid_in   = 1'b1;
      mem_we_in      = we;
      mem_waddr_in   = rd;
      mem_result_in  = res;
      mem_is_load_in = fl ? 1'($urandom) : 1'b0;
      mem_funct3_in  = 3'($urandom);
      mem_addr_lo_in = 2'($urandom);
      flush_in       = fl;
      dmem_rvalid_in = 1'($urandom);
      dmem_rdata_in  = $urandom;
      if (!fl) begin
         instret_exp++;
         if (we && rd != 0) sb.push_back('{cyc + 1, 1'b1, rd, res, 1'b0});
      end
      step();
      quiet();
   endtask

   task automatic issue_load(input logic we, input logic [4:0] rd, input logic [2:0] f3,
                             input logic [1:0] off, input logic [31:0] rdata, input int delay);
      logic [32:0] r;
      chk("load_no_stall", 64'(stall_req_out), 64'd0);
      mem_valid_in   = 1'b1;
      mem_we_in      = we;
      mem_waddr_in   = rd;
      mem_result_in  = $urandom;
      mem_is_load_in = 1'b1;
      mem_funct3_in  = f3;
      mem_addr_lo_in = off;
      flush_in       = 1'b0;
      dmem_rvalid_in = 1'b0;
      step();
      for (int i = 1; i < delay; i++) begin
         quiet();
         mem_valid_in = 1'($urandom);
         flush_in     = 1'($urandom);
         chk("load_wait_stall", 64'(stall_req_out), 64'd1);
         step();
      end
      quiet();
      mem_valid_in   = 1'($urandom);
      flush_in       = 1'($urandom);
      chk("load_resp_stall", 64'(stall_req_out), 64'd1);
      dmem_rvalid_in = 1'b1;
      dmem_rdata_in  = rdata;
      r = ref_load(f3, off, rdata);
      if (r[32]) sb.push_back('{cyc + 1, 1'b0, rd, 32'd0, 1'b1});
      else begin
         instret_exp++;
         if (we && rd != 0) sb.push_back('{cyc + 1, 1'b1, rd, r[31:0], 1'b0});
      end
      step();
      quiet();
      chk("load_stall_released", 64'(stall_req_out), 64'd0);
   endtask

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      quiet();
      reset_in = 1'b1;
      #1 reset_in = 1'b0;
      step(); step();
      chk("reset_we", 64'(we_out), 64'd0);
      chk("reset_waddr", 64'(waddr_out), 64'd0);
      chk("reset_wdata", 64'(wdata_out), 64'd0);
      chk("reset_stall", 64'(stall_req_out), 64'd0);
      chk("reset_misalign", 64'(misalign_out), 64'd0);
      reset_in = 1'b1;
      step();

      issue_alu(1'b1, 5'd5, 32'h0000_1234, 1'b0);
      issue_load(1'b1, 5'd6, 3'b000, 2'd2, 32'h0080_0000, 3);
      issue_load(1'b1, 5'd7, 3'b100, 2'd2, 32'h0080_0000, 3);
      issue_load(1'b1, 5'd8, 3'b101, 2'd2, 32'hBEEF_1234, 1);
      issue_load(1'b1, 5'd9, 3'b001, 2'd3, 32'hBEEF_1234, 2);
      chk("misalign_no_write", 64'(we_out), 64'd0);
      issue_alu(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
      chk("x0_no_write", 64'(we_out), 64'd0);
      issue_alu(1'b1, 5'd10, 32'hCAFE_F00D, 1'b1);
      chk("flush_no_write", 64'(we_out), 64'd0);
      issue_load(1'b1, 5'd11, 3'b010, 2'd0, 32'h1357_9BDF, 4);

      dmem_rvalid_in = 1'b1;
      step();
      quiet();
      chk("spurious_resp_no_write", 64'(we_out), 64'd0);

      // Reset in the middle of a pending load
      issue_alu(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0);
      mem_valid_in   = 1'b1;
      mem_we_in      = 1'b1;
      mem_waddr_in   = 5'd9;
      mem_is_load_in = 1'b1;
      mem_funct3_in  = 3'b010;
      mem_addr_lo_in = 2'd0;
      step();
      quiet();
      step();
      chk("midwait_stall", 64'(stall_req_out), 64'd1);
      #2 reset_in = 1'b0;
      #1;
      chk("async_reset_we", 64'(we_out), 64'd0);
      chk("async_reset_waddr", 64'(waddr_out), 64'd0);
      chk("async_reset_wdata", 64'(wdata_out), 64'd0);
      chk("async_reset_stall", 64'(stall_req_out), 64'd0);
      chk("async_reset_misalign", 64'(misalign_out), 64'd0);
      instret_exp = 0;
      step(); step();
      reset_in = 1'b1;
      step();
      dmem_rvalid_in = 1'b1;
      dmem_rdata_in  = 32'h5555_AAAA;
      step();
      quiet();
      chk("stale_resp_no_write", 64'(we_out), 64'd0);
      chk("stale_resp_no_stall", 64'(stall_req_out), 64'd0);

      // Retire-count scenario: 10 ADDs, one flushed, one misaligned LW
      for (int i = 0; i < 10; i++) issue_alu(1'b1, 5'(i + 1), $urandom, 1'b0);
      issue_alu(1'b1, 5'd3, $urandom, 1'b1);
      issue_load(1'b1, 5'd4, 3'b010, 2'd1, $urandom, 2);
      step();
`ifdef WB_INSTRET_EN
      chk("instret_plan", instret_out, 64'd10);
`endif

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         int kind;
         logic [4:0] rd;
         kind = int'($urandom_range(0, 9));
         rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         if (kind < 5) begin
            issue_alu(1'($urandom_range(0, 5) != 0), rd, $urandom, 1'($urandom_range(0, 7) == 0));
         end else if (kind < 9) begin
            issue_load(1'($urandom_range(0, 5) != 0), rd, 3'($urandom), 2'($urandom),
                       $urandom, int'($urandom_range(1, 4)));
         end else begin
            dmem_rvalid_in = 1'($urandom);
            step();
            quiet();
         end
      end

      step(); step();
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
`ifdef WB_INSTRET_EN
      chk("instret_final", instret_out, 64'(instret_exp));
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
